// File: rtl/instr_encoder_loader.sv
// Encodes structured RISC-V requests (lw, sw, add/sub/and/or/slt, beq) into
// 32-bit words and writes them sequentially into instruction memory.
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [2:0]            in_alu,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  full,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_ODD     = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ready_d, we_d, done_d, full_d, error_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic [CW-1:0]         count_d;
  logic [1:0]            err_code_d;

  logic [31:0] word_c;
  logic [1:0]  reject_c;
  logic [6:0]  funct7_c;
  logic [2:0]  funct3_c;

  // Instruction encoder; reject_c is non-zero when the request must be dropped
  always_comb begin
    word_c   = 32'd0;
    reject_c = ERR_NONE;
    funct7_c = 7'b0000000;
    funct3_c = 3'b000;
    case (in_kind)
      3'b000: begin
        word_c = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
        if (in_imm[12] != in_imm[11]) reject_c = ERR_RANGE;
      end
      3'b001: begin
        word_c = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
        if (in_imm[12] != in_imm[11]) reject_c = ERR_RANGE;
      end
      3'b010: begin
        case (in_alu)
          3'b000:  begin funct7_c = 7'b0000000; funct3_c = 3'b000; end
          3'b001:  begin funct7_c = 7'b0100000; funct3_c = 3'b000; end
          3'b010:  begin funct7_c = 7'b0000000; funct3_c = 3'b111; end
          3'b011:  begin funct7_c = 7'b0000000; funct3_c = 3'b110; end
          3'b100:  begin funct7_c = 7'b0000000; funct3_c = 3'b010; end
          default: reject_c = ERR_ILLEGAL;
        endcase
        word_c = {funct7_c, in_rs2, in_rs1, funct3_c, in_rd, OP_RTYPE};
      end
      3'b011: begin
        word_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                  in_imm[4:1], in_imm[11], OP_BRANCH};
        if (in_imm[0]) reject_c = ERR_ODD;
      end
      default: reject_c = ERR_ILLEGAL;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    count_d    = count;
    done_d     = done;
    full_d     = full;
    error_d    = error;
    err_code_d = err_code;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          ptr_d      = ADDR_WIDTH'(BASE_ADDR);
          count_d    = '0;
          done_d     = 1'b0;
          full_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (reject_c == ERR_NONE) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word_c;
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            count_d = count + CW'(1);
          end else begin
            error_d = 1'b1;
            if (!error) err_code_d = reject_c;
          end
          if (in_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
          // The DEPTH-th write always ends the session
          if (reject_c == ERR_NONE && count == CW'(DEPTH - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            full_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= ADDR_WIDTH'(BASE_ADDR);
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      imem_wdata <= 32'd0;
      count      <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      in_ready   <= ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      count      <= count_d;
      done       <= done_d;
      full       <= full_d;
      error      <= error_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: a 64-word instance for encoding/error sessions and a
// 4-word instance for the full-memory session, sharing the request payload.
module tb_instr_encoder_loader;

  logic clk, rst, start, in_valid, sel;
  logic [2:0] in_kind, in_alu;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic in_last;

  logic start_a, start_b, valid_a, valid_b;
  logic ready_a, we_a, done_a, full_a, error_a;
  logic [5:0] addr_a;
  logic [31:0] wdata_a;
  logic [6:0] count_a;
  logic [1:0] ec_a;
  logic ready_b, we_b, done_b, full_b, error_b;
  logic [1:0] addr_b;
  logic [31:0] wdata_b;
  logic [2:0] count_b;
  logic [1:0] ec_b;

  logic m_ready, m_we, m_done, m_full, m_error;
  logic [5:0] m_addr;
  logic [31:0] m_wdata;
  logic [6:0] m_count;
  logic [1:0] m_ec;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_wr  = 0;
  int wr_gap   = 0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign valid_a = in_valid & ~sel;
  assign valid_b = in_valid & sel;

  assign m_ready = sel ? ready_b : ready_a;
  assign m_we    = sel ? we_b : we_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_full  = sel ? full_b : full_a;
  assign m_error = sel ? error_b : error_a;
  assign m_addr  = sel ? {4'd0, addr_b} : addr_a;
  assign m_wdata = sel ? wdata_b : wdata_a;
  assign m_count = sel ? {4'd0, count_b} : count_a;
  assign m_ec    = sel ? ec_b : ec_a;

  instr_encoder_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .count(count_a), .done(done_a), .full(full_a),
    .error(error_a), .err_code(ec_a)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .count(count_b), .done(done_b), .full(full_b),
    .error(error_b), .err_code(ec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; writes are popped from the scoreboard at the negedge
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    n_checks++;
    if ((sel ? we_a : we_b) !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_instance_write: unselected imem_we=1, required 0");
    end
    if (m_we === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%08h, required no write", m_addr, m_wdata);
      end else begin
        e = sb.pop_front();
        if (m_addr !== e.addr || m_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: addr=%0d data=%08h, required addr=%0d data=%08h",
                   m_addr, m_wdata, e.addr, e.data);
        end
      end
      wr_gap  = cyc - prev_wr;
      prev_wr = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned addr, input logic [31:0] d);
    sb.push_back({6'(addr), d});
  endtask

  task automatic send(input logic [2:0] k, input logic [2:0] a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm, input logic last);
    in_kind = k; in_alu = a; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", m_we); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", m_ready); end
    n_checks++; if (m_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", m_addr); end
    n_checks++; if (m_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %08h, required 0", m_wdata); end
    n_checks++; if (m_count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", m_count); end
    n_checks++;
    if ({m_done, m_full, m_error, m_ec} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {m_done, m_full, m_error, m_ec});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    do_start();
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b, required 1", m_ready); end
    push(0, 32'hFFC4A303);
    send(3'b000, 3'b000, 5'd6, 5'd9, 5'd0, -13'sd4, 1'b0);
    n_checks++; if (m_count !== 7'd1) begin n_fail++; $display("FAIL lw_count: got %0d, required 1", m_count); end
  endtask

  task automatic test_back_to_back();
    push(1, 32'h0064A423);
    send(3'b001, 3'b000, 5'd0, 5'd9, 5'd6, 13'd8, 1'b0);
    push(2, 32'h0062E233);
    send(3'b010, 3'b011, 5'd4, 5'd5, 5'd6, 13'd0, 1'b0);
    step();
    n_checks++; if (wr_gap !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles, required 1", wr_gap); end
    n_checks++; if (m_count !== 7'd3) begin n_fail++; $display("FAIL b2b_count: got %0d, required 3", m_count); end
  endtask

  task automatic test_last();
    push(3, 32'h40418133);
    send(3'b010, 3'b001, 5'd2, 5'd3, 5'd4, 13'd0, 1'b0);
    push(4, 32'hFE420EE3);
    send(3'b011, 3'b000, 5'd0, 5'd4, 5'd4, -13'sd4, 1'b1);
    n_checks++; if (m_done !== 1'b1) begin n_fail++; $display("FAIL last_done: got %b, required 1", m_done); end
    n_checks++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL last_we_with_done: got %b, required 1", m_we); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL last_ready: got %b, required 0", m_ready); end
    n_checks++; if (m_count !== 7'd5) begin n_fail++; $display("FAIL last_count: got %0d, required 5", m_count); end
    send(3'b000, 3'b000, 5'd1, 5'd1, 5'd0, 13'd0, 1'b0);
    step();
    n_checks++; if (m_done !== 1'b1) begin n_fail++; $display("FAIL done_level: got %b, required 1", m_done); end
  endtask

  task automatic test_errors();
    do_start();
    n_checks++;
    if ({m_error, m_ec, m_done} !== 4'd0 || m_count !== 7'd0) begin
      n_fail++; $display("FAIL start_clear: err=%b code=%b done=%b count=%0d, required all 0", m_error, m_ec, m_done, m_count);
    end
    send(3'b011, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL odd_we: got %b, required 0", m_we); end
    n_checks++; if (m_error !== 1'b1) begin n_fail++; $display("FAIL odd_error: got %b, required 1", m_error); end
    n_checks++; if (m_ec !== 2'b11) begin n_fail++; $display("FAIL odd_code: got %b, required 11", m_ec); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL odd_ready: got %b, required 1", m_ready); end
    send(3'b000, 3'b000, 5'd1, 5'd2, 5'd0, 13'h0800, 1'b0);
    n_checks++; if (m_ec !== 2'b11) begin n_fail++; $display("FAIL range_code_sticky: got %b, required 11", m_ec); end
    send(3'b101, 3'b000, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    n_checks++; if (m_ec !== 2'b11 || m_error !== 1'b1) begin n_fail++; $display("FAIL illegal_code_sticky: err=%b code=%b, required 1/11", m_error, m_ec); end
    n_checks++; if (m_count !== 7'd0) begin n_fail++; $display("FAIL reject_count: got %0d, required 0", m_count); end
    push(0, 32'hFFC4A303);
    send(3'b000, 3'b000, 5'd6, 5'd9, 5'd0, -13'sd4, 1'b0);
    n_checks++; if (m_addr !== 6'd0) begin n_fail++; $display("FAIL ptr_unchanged: got %0d, required 0", m_addr); end
    start = 1'b1;
    push(1, 32'h0064A423);
    send(3'b001, 3'b000, 5'd0, 5'd9, 5'd6, 13'd8, 1'b0);
    start = 1'b0;
    n_checks++; if (m_count !== 7'd2 || m_error !== 1'b1) begin n_fail++; $display("FAIL start_in_load: count=%0d err=%b, required 2/1", m_count, m_error); end
    send(3'b101, 3'b000, 5'd0, 5'd0, 5'd0, 13'd0, 1'b1);
    n_checks++; if (m_done !== 1'b1 || m_ready !== 1'b0) begin n_fail++; $display("FAIL rejected_last: done=%b ready=%b, required 1/0", m_done, m_ready); end
    n_checks++; if (m_count !== 7'd2) begin n_fail++; $display("FAIL rejected_last_count: got %0d, required 2", m_count); end
    do_start();
    send(3'b010, 3'b101, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
    n_checks++; if (m_ec !== 2'b01) begin n_fail++; $display("FAIL illegal_alu_code: got %b, required 01", m_ec); end
    push(0, 32'h001080B3);
    send(3'b010, 3'b000, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1);
    step();
  endtask

  task automatic test_full();
    sel = 1'b1;
    do_start();
    push(0, 32'h001080B3);
    send(3'b010, 3'b000, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
    push(1, 32'h003170B3);
    send(3'b010, 3'b010, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    push(2, 32'h007322B3);
    send(3'b010, 3'b100, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0);
    push(3, 32'hFFC4A303);
    send(3'b000, 3'b000, 5'd6, 5'd9, 5'd0, -13'sd4, 1'b0);
    n_checks++; if (m_full !== 1'b1 || m_done !== 1'b1) begin n_fail++; $display("FAIL full_flags: full=%b done=%b, required 1/1", m_full, m_done); end
    n_checks++; if (m_count !== 7'd4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", m_count); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", m_ready); end
    send(3'b010, 3'b000, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1);
    step();
    do_start();
    n_checks++;
    if (m_full !== 1'b0 || m_done !== 1'b0 || m_count !== 7'd0) begin
      n_fail++; $display("FAIL full_restart: full=%b done=%b count=%0d, required 0/0/0", m_full, m_done, m_count);
    end
    push(0, 32'h0062E233);
    send(3'b010, 3'b011, 5'd4, 5'd5, 5'd6, 13'd0, 1'b0);
    n_checks++; if (m_count !== 7'd1 || m_addr !== 6'd0) begin n_fail++; $display("FAIL full_rewrite: count=%0d addr=%0d, required 1/0", m_count, m_addr); end
    send(3'b111, 3'b000, 5'd0, 5'd0, 5'd0, 13'd0, 1'b1);
    step();
    sel = 1'b0;
  endtask

  task automatic test_rst_accept();
    do_start();
    rst = 1'b1;
    send(3'b000, 3'b000, 5'd6, 5'd9, 5'd0, -13'sd4, 1'b0);
    rst = 1'b0;
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rst_accept_we: got %b, required 0", m_we); end
    n_checks++; if (m_ready !== 1'b0 || m_done !== 1'b0) begin n_fail++; $display("FAIL rst_accept_state: ready=%b done=%b, required 0/0", m_ready, m_done); end
    n_checks++; if (m_count !== 7'd0) begin n_fail++; $display("FAIL rst_accept_count: got %0d, required 0", m_count); end
    step();
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = 3'd0; in_alu = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd0;
    test_reset();
    test_lw();
    test_back_to_back();
    test_last();
    test_errors();
    test_full();
    test_rst_accept();
    step();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encodes structured RISC-V instruction requests (lw, sw, R-type add/sub/and/or/slt, beq) into 32-bit machine words and writes them sequentially into instruction memory. It produces exactly the opcode/funct/immediate formats that the core's primary and ALU decoders consume. It sits between a testbench or host program source and the instruction memory write port, and is used to preload programs before the core runs.

## Interface
- ADDR_WIDTH, 6, instruction memory word-address width; DEPTH = 2^ADDR_WIDTH words
- BASE_ADDR, 0, first word address written after start
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begins a load session
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_kind  in  3  000 LW, 001 SW, 010 RTYPE, 011 BEQ, 1xx illegal
- in_alu  in  3  RTYPE only: 000 add, 001 sub, 010 and, 011 or, 100 slt, others illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  13  signed immediate (12-bit range for LW/SW, byte offset for BEQ)
- in_last  in  1  marks the final request of a session
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_WIDTH+1  words written this session
- done  out  1  session finished (level)
- full  out  1  session ended because DEPTH words were written
- error  out  1  sticky: at least one request was rejected
- err_code  out  2  first error: 01 illegal kind/alu, 10 immediate out of range, 11 BEQ offset odd

## Operation
- States: IDLE, LOAD, DONE. After reset: IDLE; all outputs 0, and imem_addr = BASE_ADDR.
- IDLE or DONE + start → LOAD. Clears count, done, full, error, and err_code. Sets the write pointer to BASE_ADDR. start in LOAD is ignored.
- in_ready = (state == LOAD). A request is accepted when in_valid & in_ready.
- Encodings:
  - LW: imm[11:0], rs1, 010, rd, 0000011
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011
  - RTYPE: funct7, rs2, rs1, funct3, rd, 0110011
    - add 000/0000000
    - sub 000/0100000
    - and 111/0000000
    - or 110/0000000
    - slt 010/0000000
  - BEQ: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011
- Rejection rules:
  - Range error (10): LW/SW with in_imm[12] ≠ in_imm[11].
  - Odd offset (11): BEQ with in_imm[0] = 1.
  - Illegal (01): illegal kind or illegal alu code.
  - Unused fields, such as rd for SW/BEQ, are ignored.
- Valid accepted request: write it at the pointer, then increment the pointer and count.
- Rejected request: the handshake still completes. No write occurs and the pointer is unchanged. error is set, and err_code latches only if error was 0.
- Session end: an accepted request with in_last = 1 → DONE, whether that request was valid or rejected. Writing the DEPTH-th word → DONE with full = 1, and any in_last is moot. In DONE, done = 1 until the next start.

## Timing
- Request accepted at edge N: imem_we, imem_addr, and imem_wdata are valid for exactly the cycle after edge N. Latency is 1 cycle and all outputs are registered.
- Throughput is one request per cycle, back-to-back.
- count updates at the same edge as imem_we rises.
- The transition to DONE occurs at the accepting edge. in_ready is low from the next cycle, and done rises together with the final imem_we.
- imem_we is never asserted for a rejected request, or in IDLE/DONE except for the trailing write.
- The pointer never wraps. Exactly DEPTH writes is the maximum per session.
- rst is synchronous and has priority over start and over accepts in the same cycle. rst mid-LOAD drops any pending write: imem_we = 0 in the cycle after the reset edge.

## Test plan
- start; LW rd=6 rs1=9 imm=-4, last=0 → imem_wdata 0xFFC4A303 @ addr 0, count = 1.
- SW rs2=6 rs1=9 imm=8, then RTYPE or rd=4 rs1=5 rs2=6, back-to-back → 0x0064A423 @1 and 0x0062E233 @2 on consecutive cycles.
- RTYPE sub rd=2 rs1=3 rs2=4, then BEQ rs1=4 rs2=4 imm=-4 with last=1 → 0x40418133, then 0xFE420EE3. done rises with the second write; in_ready = 0 afterwards.
- Each of these is accepted without a write; pointer unchanged, error = 1, err_code stays at its first value:
  - BEQ imm=3 → err_code 11.
  - LW imm=0x0800 → err_code stays 11.
  - kind=101 → err_code stays 11.
- ADDR_WIDTH = 2 with in_valid held high → 4 writes at addresses 0–3, then full = 1, done = 1, count = 4, no fifth write. A new start clears all of these and writes again from 0.
- rst asserted in the same cycle a request is accepted → no imem_we in the next cycle; state IDLE, count = 0.
